// File: rtl/adat_sample_scheduler.sv
// ADAT frame-to-beat scheduler: captures one 8-channel frame and streams the
// enabled slots one per handshake, in normal or S/MUX2 slot order.
module adat_sample_scheduler #(
  parameter int OVR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0][23:0]     i_channels,
  input  logic                 i_valid,
  input  logic                 i_locked,
  input  logic [7:0]           i_ch_mask,
  input  logic                 i_smux2,
  output logic [23:0]          o_data,
  output logic [2:0]           o_ch,
  output logic                 o_sub,
  output logic                 o_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_overrun,
  output logic [OVR_CNT_W-1:0] o_overrun_cnt
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [7:0][23:0] sh_data;
  logic             sh_smux2;
  logic [7:0]       sh_pend;   // slots still to send, indexed by position in slot order
  logic [7:0]       cap_ord;
  logic [7:0]       src_ord, rest;
  logic             src_smux, found, load;
  logic [2:0]       pos, phys;
  logic [23:0]      sel_data;
  logic             hs, capture, drop;

  // Slot position -> physical channel; S/MUX2 sends evens first, then odds.
  function automatic logic [2:0] slot_phys(input logic [2:0] p, input logic smux);
    return smux ? {p[1:0], p[2]} : p;
  endfunction

  for (genvar p = 0; p < 8; p++) begin : g_ord
    assign cap_ord[p] = i_ch_mask[slot_phys(3'(p), i_smux2)];
  end

  assign hs      = o_valid && i_ready;
  assign capture = i_valid && i_locked && (state == IDLE || (hs && o_last));
  assign drop    = i_valid && i_locked && state == SEND && !(hs && o_last);

  // First beat of a fresh capture comes straight from the inputs, later beats from shadow.
  always_comb begin
    src_smux = capture ? i_smux2 : sh_smux2;
    src_ord  = capture ? cap_ord : sh_pend;
    pos      = '0;
    found    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (src_ord[i] && !found) begin
        pos   = 3'(i);
        found = 1'b1;
      end
    end
    phys     = slot_phys(pos, src_smux);
    rest     = src_ord & ~(8'd1 << pos);
    sel_data = capture ? i_channels[phys] : sh_data[phys];
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (capture && found) begin
          state_nxt = SEND;
          load      = 1'b1;
        end
      end
      SEND: begin
        if (!i_locked) begin
          state_nxt = IDLE;
        end else if (capture) begin
          if (found) load = 1'b1;
          else       state_nxt = IDLE;
        end else if (hs) begin
          if (o_last) state_nxt = IDLE;
          else        load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sh_data       <= '0;
      sh_smux2      <= 1'b0;
      sh_pend       <= '0;
      o_data        <= '0;
      o_ch          <= '0;
      o_sub         <= 1'b0;
      o_last        <= 1'b0;
      o_valid       <= 1'b0;
      o_overrun     <= 1'b0;
      o_overrun_cnt <= '0;
    end else begin
      if (capture) begin
        sh_data  <= i_channels;
        sh_smux2 <= i_smux2;
      end
      if (load) begin
        o_data  <= sel_data;
        o_ch    <= src_smux ? {1'b0, phys[2:1]} : phys;
        o_sub   <= src_smux & phys[0];
        o_last  <= (rest == 8'd0);
        sh_pend <= rest;
      end
      o_valid   <= (state_nxt == SEND);
      o_overrun <= drop;
      if (drop && o_overrun_cnt != '1) o_overrun_cnt <= o_overrun_cnt + OVR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adat_sample_scheduler.sv
// Bench for adat_sample_scheduler: directed scenarios plus random frames checked
// against a queue of expected beats built from the slot-order rules.
module tb_adat_sample_scheduler;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0][23:0] i_channels;
  logic            i_valid, i_locked, i_smux2, i_ready;
  logic [7:0]      i_ch_mask;
  logic [23:0]     o_data, o_data2;
  logic [2:0]      o_ch, o_ch2;
  logic            o_sub, o_last, o_valid, o_overrun;
  logic            o_sub2, o_last2, o_valid2, o_overrun2;
  logic [7:0]      o_cnt;
  logic [1:0]      o_cnt2;

  always #5 clk = ~clk;

  adat_sample_scheduler #(.OVR_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_channels(i_channels), .i_valid(i_valid),
    .i_locked(i_locked), .i_ch_mask(i_ch_mask), .i_smux2(i_smux2),
    .o_data(o_data), .o_ch(o_ch), .o_sub(o_sub), .o_last(o_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_overrun(o_overrun), .o_overrun_cnt(o_cnt));

  adat_sample_scheduler #(.OVR_CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst_n), .i_channels(i_channels), .i_valid(i_valid),
    .i_locked(i_locked), .i_ch_mask(i_ch_mask), .i_smux2(i_smux2),
    .o_data(o_data2), .o_ch(o_ch2), .o_sub(o_sub2), .o_last(o_last2), .o_valid(o_valid2),
    .i_ready(i_ready), .o_overrun(o_overrun2), .o_overrun_cnt(o_cnt2));

  typedef struct {
    logic [23:0] data;
    logic [2:0]  ch;
    logic        sub;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one frame: walk the slot order, keep enabled channels.
  task automatic build(input logic [7:0][23:0] ch, input logic [7:0] mask, input bit smux);
    int n = $countones(mask);
    int k = 0;
    for (int s = 0; s < 8; s++) begin
      int ph = smux ? ((s < 4) ? 2 * s : 2 * (s - 4) + 1) : s;
      if (mask[ph]) begin
        beat_t b;
        k++;
        b.data = ch[ph];
        b.ch   = smux ? 3'(ph / 2) : 3'(ph);
        b.sub  = smux ? ph[0] : 1'b0;
        b.last = (k == n);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic logic [7:0][23:0] rnd_frame();
    logic [7:0][23:0] f;
    for (int i = 0; i < 8; i++) f[i] = 24'($urandom);
    return f;
  endfunction

  // Called at a negedge; capture happens at the following posedge.
  task automatic start(input logic [7:0][23:0] ch, input logic [7:0] mask, input bit smux);
    i_valid = 1'b1; i_channels = ch; i_ch_mask = mask; i_smux2 = smux;
    build(ch, mask, smux);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // mode 0: ready=1, 1: ready toggles starting at 0, 2: random ready.
  task automatic drain(input int mode, input bit b2b, input logic [7:0][23:0] nch,
                       input logic [7:0] nmask, input bit nsmux);
    int budget = 300;
    bit tog = 1'b0;
    bit rdy;
    while (exp_q.size() > 0 && budget > 0) begin
      chk("beat_valid", 32'(o_valid), 32'd1);
      chk("beat_data", 32'(o_data), 32'(exp_q[0].data));
      chk("beat_ch", 32'(o_ch), 32'(exp_q[0].ch));
      chk("beat_sub", 32'(o_sub), 32'(exp_q[0].sub));
      chk("beat_last", 32'(o_last), 32'(exp_q[0].last));
      chk("no_overrun", 32'(o_overrun), 32'd0);
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = !tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_ready = rdy;
      i_valid = 1'b0;
      i_channels = rnd_frame();
      i_ch_mask = 8'($urandom);
      i_smux2 = 1'($urandom_range(0, 1));
      if (rdy) begin
        if (exp_q.size() == 1 && b2b) begin
          void'(exp_q.pop_front());
          i_valid = 1'b1; i_channels = nch; i_ch_mask = nmask; i_smux2 = nsmux;
          build(nch, nmask, nsmux);
          b2b = 1'b0;
        end else begin
          void'(exp_q.pop_front());
        end
      end
      budget--;
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("drain_budget", 32'(budget > 0), 32'd1);
    chk("idle_after_frame", 32'(o_valid), 32'd0);
  endtask

  logic [7:0][23:0] f_norm, f_smux, f_b;

  initial begin
    f_norm = {24'hABCDEF, 24'h789ABC, 24'h6789AB, 24'h56789A,
              24'h456789, 24'h345678, 24'h234567, 24'h123456};
    f_smux = {24'hDD1111, 24'hDD0000, 24'hCC1111, 24'hCC0000,
              24'hBB1111, 24'hBB0000, 24'hAA1111, 24'hAA0000};
    rst_n = 1'b0; i_valid = 1'b0; i_locked = 1'b1; i_smux2 = 1'b0;
    i_ready = 1'b1; i_ch_mask = 8'h00; i_channels = '0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // normal order, full mask
    start(f_norm, 8'hFF, 1'b0);
    drain(0, 1'b0, '0, 8'h00, 1'b0);

    // S/MUX2 order
    start(f_smux, 8'hFF, 1'b1);
    drain(0, 1'b0, '0, 8'h00, 1'b0);

    // sparse mask with toggling backpressure
    start(f_norm, 8'b1010_0101, 1'b0);
    drain(1, 1'b0, '0, 8'h00, 1'b0);

    // empty mask and unlocked i_valid produce nothing
    start(f_norm, 8'h00, 1'b0);
    chk("mask0_valid", 32'(o_valid), 32'd0);
    i_locked = 1'b0;
    start(f_norm, 8'hFF, 1'b0);
    exp_q.delete();
    chk("unlocked_valid", 32'(o_valid), 32'd0);
    chk("unlocked_ovr", 32'(o_overrun), 32'd0);
    i_locked = 1'b1;

    // overruns while held in SEND
    i_ready = 1'b0;
    start(f_norm, 8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_channels = rnd_frame(); i_ch_mask = 8'hFF;
      @(negedge clk);
      i_valid = 1'b0;
      exp_cnt++;
      chk("ovr_pulse", 32'(o_overrun), 32'd1);
      chk("ovr_cnt", 32'(o_cnt), 32'(exp_cnt));
      chk("ovr_cnt_sat", 32'(o_cnt2), 32'((exp_cnt > 3) ? 3 : exp_cnt));
      chk("ovr_hold_data", 32'(o_data), 32'(exp_q[0].data));
      @(negedge clk);
      chk("ovr_one_cycle", 32'(o_overrun), 32'd0);
    end
    drain(2, 1'b0, '0, 8'h00, 1'b0);
    chk("ovr_cnt_final", 32'(o_cnt), 32'd5);

    // back-to-back frames
    f_b = rnd_frame();
    start(f_norm, 8'hFF, 1'b0);
    drain(0, 1'b1, f_b, 8'hFF, 1'b1);

    // lock loss after three beats; 4th beat is handshaken in the abort cycle
    i_ready = 1'b1;
    start(f_norm, 8'hFF, 1'b0);
    repeat (3) begin
      chk("abort_pre_data", 32'(o_data), 32'(exp_q[0].data));
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    i_locked = 1'b0;
    @(negedge clk);
    exp_q.delete();
    repeat (3) begin
      chk("abort_valid", 32'(o_valid), 32'd0);
      chk("abort_ovr", 32'(o_overrun), 32'd0);
      @(negedge clk);
    end
    i_locked = 1'b1;

    // random frames, random backpressure, optional back-to-back successor
    for (int r = 0; r < 14; r++) begin
      logic [7:0] m;
      m = 8'($urandom);
      start(rnd_frame(), m, 1'($urandom_range(0, 1)));
      if (m == 8'h00) chk("rnd_mask0", 32'(o_valid), 32'd0);
      else drain(2, 1'($urandom_range(0, 1)), rnd_frame(), 8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // asynchronous reset mid-frame
    i_ready = 1'b1;
    start(f_norm, 8'hFF, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_data", 32'(o_data), 32'd0);
    chk("arst_ch", 32'(o_ch), 32'd0);
    chk("arst_last", 32'(o_last), 32'd0);
    chk("arst_cnt", 32'(o_cnt), 32'd0);
    chk("arst_cnt2", 32'(o_cnt2), 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(o_valid), 32'd0);
    end
    start(f_smux, 8'hF0, 1'b1);
    drain(0, 1'b0, '0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
